// File: rtl/rca_pipe.sv
// rtl/rca_pipe.sv - pipelined ripple-carry adder/subtractor with valid/ready flow control
module rca_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  logic             r_init;
  logic             w_stall;
  logic             w_adv;
  logic             w_acc;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_init <= 1'b0;
    else        r_init <= 1'b1;
  end

  assign w_stall  = out_valid && !out_ready;
  assign w_adv    = !w_stall;
  assign in_ready = r_init && w_adv;
  assign w_acc    = in_valid && in_ready;
  assign w_b_eff  = sub ? ~b : b;
  assign w_c0     = sub | cin;

  // Stage k adds slice k; upper operand slices shrink by SEG per stage, the sum grows by SEG.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = WIDTH - k * SEG;

    logic [RW-1:0]        w_a;
    logic [RW-1:0]        w_b;
    logic                 w_ci;
    logic                 w_vi;
    logic [SEG:0]         w_add;
    logic [(k+1)*SEG-1:0] w_s_next;
    logic                 r_v;
    logic                 r_c;
    logic [(k+1)*SEG-1:0] r_s;

    if (k == 0) begin : g_src
      assign w_a      = a;
      assign w_b      = w_b_eff;
      assign w_ci     = w_c0;
      assign w_vi     = w_acc;
      assign w_s_next = w_add[SEG-1:0];
    end else begin : g_src
      assign w_a      = g_st[k-1].g_skew.r_a;
      assign w_b      = g_st[k-1].g_skew.r_b;
      assign w_ci     = g_st[k-1].r_c;
      assign w_vi     = g_st[k-1].r_v;
      assign w_s_next = {w_add[SEG-1:0], g_st[k-1].r_s};
    end

    assign w_add = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + (SEG+1)'(w_ci);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_vi;
        if (w_vi) begin
          r_c <= w_add[SEG];
          r_s <= w_s_next;
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [RW-SEG-1:0] r_a;
      logic [RW-SEG-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_vi) begin
          r_a <= w_a[RW-1:SEG];
          r_b <= w_b[RW-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic w_ovf;
      logic r_ovf;

      // a^b^s at the MSB recovers the carry into it
      assign w_ovf = w_a[SEG-1] ^ w_b[SEG-1] ^ w_add[SEG-1] ^ w_add[SEG];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_ovf <= 1'b0;
        else if (w_adv && w_vi)  r_ovf <= w_ovf;
      end
    end
  end

  assign out_valid = g_st[STAGES-1].r_v;
  assign sum       = g_st[STAGES-1].r_s;
  assign cout      = g_st[STAGES-1].r_c;
  assign ovf       = g_st[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_rca_pipe.sv
// tb/tb_rca_pipe.sv - self-checking bench for rca_pipe
module tb_rca_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_err  = 0;
  int n_chk  = 0;
  int n_done = 0;

  logic       rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, sum;

  rca_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Golden result packed as {cout, ovf, sum[15:0]}
  function automatic logic [17:0] model(input int w, input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [16:0] mask;
    logic [15:0] bb;
    logic [16:0] full;
    logic [15:0] s;
    logic        ov;
    mask = (17'd1 << w) - 17'd1;
    bb   = (ms ? ~mb : mb) & mask[15:0];
    full = {1'b0, ma} + {1'b0, bb} + 17'(ms | mc);
    s    = full[15:0] & mask[15:0];
    ov   = (ma[w-1] == bb[w-1]) && (s[w-1] != ma[w-1]);
    return {full[w], ov, s};
  endfunction

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic       vs;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [17:0] q[$];
    logic [17:0] frozen;
    int          idx;
    int          got;

    vt[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[3] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[6] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[8] = '{8'h0F, 8'h0F, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0};
    vt[9] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {cout, ovf, sum}, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("pre_edge_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("post_edge_in_ready", in_ready, 1);

    // Single beats: latency of two edges with out_ready held high
    for (int i = 0; i < 10; i++) begin
      a = vt[i].va; b = vt[i].vb; cin = vt[i].vc; sub = vt[i].vs;
      in_valid = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d_lat1", i), out_valid, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_lat2", i), out_valid, 1);
      check($sformatf("vec%0d_res", i), {cout, ovf, sum}, {vt[i].ec, vt[i].eo, vt[i].es});
      @(posedge clk); #1;
      check($sformatf("vec%0d_drained", i), out_valid, 0);
    end

    // Six back-to-back beats with a three-cycle sink stall mid-stream
    idx = 0; got = 0; frozen = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (idx < 6);
      a   = 8'h13 + 8'(idx * 37);
      b   = 8'h2C + 8'(idx * 91);
      cin = idx[1];
      sub = idx[0];
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        check("stall_out_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        if (cyc == 3) frozen = {cout, ovf, 8'h00, sum};
        else          check("stall_hold", {cout, ovf, 8'h00, sum}, frozen);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stream_unexpected", 1, 0);
        end else begin
          check("stream_res", {cout, ovf, 8'h00, sum}, q.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(8, {8'h00, a}, {8'h00, b}, cin, sub));
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stream_count", got, 6);
    check("stream_q_empty", q.size(), 0);

    // Reset while two beats are in flight
    out_ready = 1'b0;
    a = 8'h7F; b = 8'h01; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_rst_pre_valid", out_valid, 1);
    check("mid_rst_pre_res", {cout, ovf, sum}, {1'b0, 1'b1, 8'h80});
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_outputs", {cout, ovf, sum}, 0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", out_valid, 0);
    end

    for (int t = 0; t < 20000 && n_done < 4; t++) @(posedge clk);
    check("rnd_done", n_done, 4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Random regression over other geometries with random in_valid/out_ready
  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int W = (g == 3) ? 16 : 8;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 4;

    logic         rn, iv, ir, ov, ordy, ci, sb, co, of;
    logic [W-1:0] ra, rb, rs;

    rca_pipe #(.WIDTH(W), .STAGES(S)) u_rnd (
      .clk(clk), .rst_n(rn), .in_valid(iv), .in_ready(ir),
      .a(ra), .b(rb), .cin(ci), .sub(sb),
      .out_valid(ov), .out_ready(ordy),
      .sum(rs), .cout(co), .ovf(of)
    );

    initial begin
      logic [17:0] rq[$];
      rn = 1'b0; iv = 1'b0; ordy = 1'b0; ci = 1'b0; sb = 1'b0;
      ra = '0; rb = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rn = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 400; c++) begin
        iv   = (c < 300) && ($urandom_range(0, 3) != 0);
        ordy = (c >= 300) || ($urandom_range(0, 3) != 0);
        ra   = W'($urandom);
        rb   = W'($urandom);
        ci   = 1'($urandom);
        sb   = 1'($urandom);
        #1;
        if (ov && ordy) begin
          if (rq.size() == 0) check($sformatf("rnd%0d_unexpected", g), 1, 0);
          else check($sformatf("rnd%0d_res", g), {co, of, 16'(rs)}, rq.pop_front());
        end
        if (iv && ir) rq.push_back(model(W, 16'(ra), 16'(rb), ci, sb));
        @(posedge clk); #1;
      end
      check($sformatf("rnd%0d_q_empty", g), rq.size(), 0);
      n_done++;
    end
  end

endmodule
